// File: rtl/algo_2rw_rsp_track_if.sv
// Two-port memory read-response bundle: command/response strobes from the memory side
// and the tagged responses, sticky error flags and counters produced by the tracker.
interface algo_2rw_rsp_track_if #(
    parameter int WIDTH   = 32,
    parameter int BITADDR = 13,
    parameter int BITPADR = 15,
    parameter int CNTW    = 16
);
    logic                   ready;
    logic [1:0]             rw_read;
    logic [1:0]             rw_write;
    logic [2*BITADDR-1:0]   rw_addr;
    logic [1:0]             rw_vld;
    logic [1:0]             rw_serr;
    logic [1:0]             rw_derr;
    logic [2*WIDTH-1:0]     rw_dout;
    logic [2*BITPADR-1:0]   rw_padr;
    logic                   clr;

    logic [1:0]             out_vld;
    logic [2*BITADDR-1:0]   out_addr;
    logic [2*WIDTH-1:0]     out_dout;
    logic [2*BITPADR-1:0]   out_padr;
    logic [1:0]             out_serr;
    logic [1:0]             out_derr;
    logic [1:0]             err_cmd;
    logic [1:0]             err_miss;
    logic [1:0]             err_unexp;
    logic [2*CNTW-1:0]      serr_cnt;
    logic [2*CNTW-1:0]      derr_cnt;
    logic                   busy;

    modport master (
        output ready, rw_read, rw_write, rw_addr, rw_vld, rw_serr, rw_derr,
               rw_dout, rw_padr, clr,
        input  out_vld, out_addr, out_dout, out_padr, out_serr, out_derr,
               err_cmd, err_miss, err_unexp, serr_cnt, derr_cnt, busy
    );

    modport slave (
        input  ready, rw_read, rw_write, rw_addr, rw_vld, rw_serr, rw_derr,
               rw_dout, rw_padr, clr,
        output out_vld, out_addr, out_dout, out_padr, out_serr, out_derr,
               err_cmd, err_miss, err_unexp, serr_cnt, derr_cnt, busy
    );
endinterface

// File: rtl/algo_2rw_rsp_track.sv
// Tracks reads on a two-port memory with fixed read latency: tags each response with its
// request address and flags missing, unexpected and illegal commands per port.
module algo_2rw_rsp_track #(
    parameter int WIDTH      = 32,
    parameter int BITADDR    = 13,
    parameter int BITPADR    = 15,
    parameter int READ_DELAY = 3,
    parameter int CNTW       = 16
) (
    input logic                 clk,
    input logic                 rst,
    algo_2rw_rsp_track_if.slave bus
);

    logic [1:0] portBusy;

    for (genvar p = 0; p < 2; p++) begin : gPort
        logic [READ_DELAY-1:0] pipeValid;
        logic [BITADDR-1:0]    pipeAddr [READ_DELAY];
        logic                  acceptRead;
        logic                  badCmd;
        logic                  tailValid;
        logic                  rspVld;
        logic                  matchRsp;
        logic                  outVld;
        logic [BITADDR-1:0]    outAddr;
        logic [WIDTH-1:0]      outDout;
        logic [BITPADR-1:0]    outPadr;
        logic                  outSerr;
        logic                  outDerr;
        logic                  errCmd;
        logic                  errMiss;
        logic                  errUnexp;
        logic [CNTW-1:0]       serrCnt;
        logic [CNTW-1:0]       derrCnt;

        assign acceptRead = bus.ready & bus.rw_read[p] & ~bus.rw_write[p];
        assign badCmd     = bus.ready & bus.rw_read[p] & bus.rw_write[p];
        assign tailValid  = pipeValid[READ_DELAY-1];
        assign rspVld     = bus.rw_vld[p];
        assign matchRsp   = tailValid & rspVld;

        // Stage 0 holds the read accepted on the previous edge; the last stage is due now.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pipeValid <= '0;
                for (int i = 0; i < READ_DELAY; i++) pipeAddr[i] <= '0;
            end else begin
                pipeValid[0] <= acceptRead;
                pipeAddr[0]  <= bus.rw_addr[p*BITADDR +: BITADDR];
                for (int i = 1; i < READ_DELAY; i++) begin
                    pipeValid[i] <= pipeValid[i-1];
                    pipeAddr[i]  <= pipeAddr[i-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                outVld  <= 1'b0;
                outAddr <= '0;
                outDout <= '0;
                outPadr <= '0;
                outSerr <= 1'b0;
                outDerr <= 1'b0;
            end else begin
                outVld <= matchRsp;
                if (matchRsp) begin
                    outAddr <= pipeAddr[READ_DELAY-1];
                    outDout <= bus.rw_dout[p*WIDTH +: WIDTH];
                    outPadr <= bus.rw_padr[p*BITPADR +: BITPADR];
                    outSerr <= bus.rw_serr[p];
                    outDerr <= bus.rw_derr[p];
                end
            end
        end

        // A clear in the same cycle overrides any flag set or counter increment.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                errCmd   <= 1'b0;
                errMiss  <= 1'b0;
                errUnexp <= 1'b0;
                serrCnt  <= '0;
                derrCnt  <= '0;
            end else if (bus.clr) begin
                errCmd   <= 1'b0;
                errMiss  <= 1'b0;
                errUnexp <= 1'b0;
                serrCnt  <= '0;
                derrCnt  <= '0;
            end else begin
                if (badCmd)                  errCmd   <= 1'b1;
                if (tailValid && !rspVld)    errMiss  <= 1'b1;
                if (rspVld && !tailValid)    errUnexp <= 1'b1;
                if (matchRsp && bus.rw_serr[p] && (serrCnt != {CNTW{1'b1}}))
                    serrCnt <= serrCnt + 1'b1;
                if (matchRsp && bus.rw_derr[p] && (derrCnt != {CNTW{1'b1}}))
                    derrCnt <= derrCnt + 1'b1;
            end
        end

        assign bus.out_vld[p]                       = outVld;
        assign bus.out_addr[p*BITADDR +: BITADDR]   = outAddr;
        assign bus.out_dout[p*WIDTH +: WIDTH]       = outDout;
        assign bus.out_padr[p*BITPADR +: BITPADR]   = outPadr;
        assign bus.out_serr[p]                      = outSerr;
        assign bus.out_derr[p]                      = outDerr;
        assign bus.err_cmd[p]                       = errCmd;
        assign bus.err_miss[p]                      = errMiss;
        assign bus.err_unexp[p]                     = errUnexp;
        assign bus.serr_cnt[p*CNTW +: CNTW]         = serrCnt;
        assign bus.derr_cnt[p*CNTW +: CNTW]         = derrCnt;
        assign portBusy[p]                          = |pipeValid;
    end

    assign bus.busy = |portBusy;

endmodule

// File: tb/tb_algo_2rw_rsp_track.sv
// Randomized bench for algo_2rw_rsp_track: a transaction-level model keyed by due cycle
// predicts responses, flags and counters, plus directed latency/saturation/reset scenarios.
module tb_algo_2rw_rsp_track;

    localparam int RD    = 3;
    localparam int CNTW  = 4;
    localparam int CMAX  = (1 << CNTW) - 1;

    logic clk;
    logic rst;

    algo_2rw_rsp_track_if #(.WIDTH(32), .BITADDR(13), .BITPADR(15), .CNTW(CNTW)) bus ();

    algo_2rw_rsp_track #(
        .WIDTH(32), .BITADDR(13), .BITPADR(15), .READ_DELAY(RD), .CNTW(CNTW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Outstanding reads, keyed by (acceptance cycle * 2 + port).
    logic [12:0] pend [int];
    logic [1:0]  mOutVld, mOutSerr, mOutDerr, mErrCmd, mErrMiss, mErrUnexp;
    logic [25:0] mOutAddr;
    logic [63:0] mOutDout;
    logic [29:0] mOutPadr;
    int          mSerrCnt [2];
    int          mDerrCnt [2];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic resetModel();
        pend.delete();
        mOutVld = '0; mOutSerr = '0; mOutDerr = '0;
        mErrCmd = '0; mErrMiss = '0; mErrUnexp = '0;
        mOutAddr = '0; mOutDout = '0; mOutPadr = '0;
        for (int p = 0; p < 2; p++) begin
            mSerrCnt[p] = 0;
            mDerrCnt[p] = 0;
        end
    endtask

    task automatic compareAll();
        logic [7:0] sc, dc;
        sc = {mSerrCnt[1][3:0], mSerrCnt[0][3:0]};
        dc = {mDerrCnt[1][3:0], mDerrCnt[0][3:0]};
        checkOutput("out_vld",   64'(bus.out_vld),   64'(mOutVld));
        checkOutput("out_addr",  64'(bus.out_addr),  64'(mOutAddr));
        checkOutput("out_dout",  bus.out_dout,       mOutDout);
        checkOutput("out_padr",  64'(bus.out_padr),  64'(mOutPadr));
        checkOutput("out_serr",  64'(bus.out_serr),  64'(mOutSerr));
        checkOutput("out_derr",  64'(bus.out_derr),  64'(mOutDerr));
        checkOutput("err_cmd",   64'(bus.err_cmd),   64'(mErrCmd));
        checkOutput("err_miss",  64'(bus.err_miss),  64'(mErrMiss));
        checkOutput("err_unexp", 64'(bus.err_unexp), 64'(mErrUnexp));
        checkOutput("serr_cnt",  64'(bus.serr_cnt),  64'(sc));
        checkOutput("derr_cnt",  64'(bus.derr_cnt),  64'(dc));
        checkOutput("busy",      64'(bus.busy),      64'(pend.num() > 0));
    endtask

    task automatic modelStep(input logic rdy, input logic [1:0] rd, input logic [1:0] wr,
                             input logic [25:0] addr, input logic [1:0] vld,
                             input logic [1:0] se, input logic [1:0] de,
                             input logic [63:0] dout, input logic [29:0] padr, input logic cl);
        int tk;
        bit tail;
        bit match;
        for (int p = 0; p < 2; p++) begin
            tk    = (cyc - RD) * 2 + p;
            tail  = pend.exists(tk);
            match = tail && vld[p];
            mOutVld[p] = match;
            if (match) begin
                mOutAddr[p*13 +: 13] = pend[tk];
                mOutDout[p*32 +: 32] = dout[p*32 +: 32];
                mOutPadr[p*15 +: 15] = padr[p*15 +: 15];
                mOutSerr[p] = se[p];
                mOutDerr[p] = de[p];
                if (se[p] && mSerrCnt[p] < CMAX) mSerrCnt[p]++;
                if (de[p] && mDerrCnt[p] < CMAX) mDerrCnt[p]++;
            end
            if (tail && !vld[p]) mErrMiss[p]  = 1'b1;
            if (!tail && vld[p]) mErrUnexp[p] = 1'b1;
            if (rdy && rd[p] && wr[p]) mErrCmd[p] = 1'b1;
            if (tail) pend.delete(tk);
            if (rdy && rd[p] && !wr[p]) pend[cyc * 2 + p] = addr[p*13 +: 13];
        end
        if (cl) begin
            mErrCmd = '0; mErrMiss = '0; mErrUnexp = '0;
            for (int p = 0; p < 2; p++) begin
                mSerrCnt[p] = 0;
                mDerrCnt[p] = 0;
            end
        end
    endtask

    task automatic setIdle();
        bus.ready = 1'b0; bus.rw_read = '0; bus.rw_write = '0; bus.rw_addr = '0;
        bus.rw_vld = '0; bus.rw_serr = '0; bus.rw_derr = '0; bus.rw_dout = '0;
        bus.rw_padr = '0; bus.clr = 1'b0;
    endtask

    // One cycle: check state left by the previous edge, then present this cycle's inputs.
    task automatic applyStimulus(input logic rdy, input logic [1:0] rd, input logic [1:0] wr,
                                 input logic [25:0] addr, input logic [1:0] vld,
                                 input logic [1:0] se, input logic [1:0] de,
                                 input logic [63:0] dout, input logic [29:0] padr, input logic cl);
        @(negedge clk);
        compareAll();
        bus.ready = rdy; bus.rw_read = rd; bus.rw_write = wr; bus.rw_addr = addr;
        bus.rw_vld = vld; bus.rw_serr = se; bus.rw_derr = de; bus.rw_dout = dout;
        bus.rw_padr = padr; bus.clr = cl;
        modelStep(rdy, rd, wr, addr, vld, se, de, dout, padr, cl);
        cyc++;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 2'b00, 2'b00, '0, 2'b00, 2'b00, 2'b00, '0, '0, 1'b0);
    endtask

    task automatic clrCycle();
        applyStimulus(1'b1, 2'b00, 2'b00, '0, 2'b00, 2'b00, 2'b00, '0, '0, 1'b1);
    endtask

    task automatic doReset();
        @(negedge clk);
        #2 rst = 1'b0;
        resetModel();
        #1 compareAll();
        setIdle();
        @(negedge clk);
        rst = 1'b1;
        cyc += 4;
    endtask

    task automatic randomPhase(input int n);
        logic [1:0] rd, wr, vld, se, de;
        logic       rdy, cl;
        for (int k = 0; k < n; k++) begin
            rdy = ($urandom_range(0, 99) < 90);
            cl  = ($urandom_range(0, 99) < 2);
            for (int p = 0; p < 2; p++) begin
                rd[p]  = ($urandom_range(0, 99) < 50);
                wr[p]  = ($urandom_range(0, 99) < 8);
                se[p]  = ($urandom_range(0, 99) < 25);
                de[p]  = ($urandom_range(0, 99) < 25);
                vld[p] = pend.exists((cyc - RD) * 2 + p) ? ($urandom_range(0, 99) < 85)
                                                         : ($urandom_range(0, 99) < 4);
            end
            applyStimulus(rdy, rd, wr, 26'($urandom), vld, se, de,
                          {$urandom, $urandom}, 30'($urandom), cl);
        end
    endtask

    initial begin
        rst = 1'b0;
        setIdle();
        resetModel();
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_out_vld", 64'(bus.out_vld), 64'd0);
        rst = 1'b1;

        // Single port-0 read, response three cycles later.
        applyStimulus(1'b1, 2'b01, 2'b00, 26'h12, 2'b00, 2'b00, 2'b00, '0, '0, 1'b0);
        idleCycle();
        idleCycle();
        applyStimulus(1'b1, 2'b00, 2'b00, '0, 2'b01, 2'b00, 2'b00, 64'hA5A5, 30'h1234, 1'b0);
        idleCycle();
        checkOutput("lat_out_vld",  64'(bus.out_vld), 64'h1);
        checkOutput("lat_out_addr", 64'(bus.out_addr[12:0]), 64'h12);
        checkOutput("lat_out_dout", 64'(bus.out_dout[31:0]), 64'hA5A5);
        checkOutput("lat_flags",    64'({bus.err_cmd, bus.err_miss, bus.err_unexp}), 64'h0);

        // Three port-1 reads, middle response missing.
        applyStimulus(1'b1, 2'b10, 2'b00, 26'(1) << 13, 2'b00, 2'b00, 2'b00, '0, '0, 1'b0);
        applyStimulus(1'b1, 2'b10, 2'b00, 26'(2) << 13, 2'b00, 2'b00, 2'b00, '0, '0, 1'b0);
        applyStimulus(1'b1, 2'b10, 2'b00, 26'(3) << 13, 2'b00, 2'b00, 2'b00, '0, '0, 1'b0);
        applyStimulus(1'b1, 2'b00, 2'b00, '0, 2'b10, 2'b00, 2'b00, '0, '0, 1'b0);
        idleCycle();
        checkOutput("miss_vld4",  64'(bus.out_vld), 64'h2);
        checkOutput("miss_addr4", 64'(bus.out_addr[25:13]), 64'h1);
        applyStimulus(1'b1, 2'b00, 2'b00, '0, 2'b10, 2'b00, 2'b00, '0, '0, 1'b0);
        checkOutput("miss_flag",  64'(bus.err_miss), 64'h2);
        idleCycle();
        checkOutput("miss_vld6",  64'(bus.out_vld), 64'h2);
        checkOutput("miss_addr6", 64'(bus.out_addr[25:13]), 64'h3);

        // Unexpected response, then clear.
        clrCycle();
        applyStimulus(1'b1, 2'b00, 2'b00, '0, 2'b01, 2'b00, 2'b00, '0, '0, 1'b0);
        idleCycle();
        checkOutput("unexp_set", 64'(bus.err_unexp), 64'h1);
        checkOutput("unexp_no_vld", 64'(bus.out_vld), 64'h0);
        clrCycle();
        idleCycle();
        checkOutput("unexp_clr", 64'({bus.err_unexp, bus.err_miss}), 64'h0);

        // Back-to-back reads with double-bit errors saturate the counter.
        clrCycle();
        for (int i = 0; i < 21; i++)
            applyStimulus(1'b1, (i < 18) ? 2'b01 : 2'b00, 2'b00, 26'(i),
                          (i >= 3) ? 2'b01 : 2'b00, 2'b00, 2'b01, 64'(i), '0, 1'b0);
        idleCycle();
        checkOutput("derr_sat",  64'(bus.derr_cnt[3:0]), 64'd15);
        checkOutput("serr_zero", 64'(bus.serr_cnt), 64'd0);
        checkOutput("b2b_last_addr", 64'(bus.out_addr[12:0]), 64'd17);

        // Illegal read+write command with and without ready.
        clrCycle();
        applyStimulus(1'b1, 2'b10, 2'b10, '0, 2'b00, 2'b00, 2'b00, '0, '0, 1'b0);
        idleCycle();
        checkOutput("cmd_set",  64'(bus.err_cmd), 64'h2);
        checkOutput("cmd_busy", 64'(bus.busy), 64'h0);
        clrCycle();
        applyStimulus(1'b0, 2'b10, 2'b10, '0, 2'b00, 2'b00, 2'b00, '0, '0, 1'b0);
        idleCycle();
        checkOutput("cmd_notready", 64'(bus.err_cmd), 64'h0);

        randomPhase(3000);

        // Reset discards an in-flight read; its late response is unexpected.
        clrCycle();
        idleCycle();
        applyStimulus(1'b1, 2'b01, 2'b00, 26'h5, 2'b00, 2'b00, 2'b00, '0, '0, 1'b0);
        doReset();
        applyStimulus(1'b1, 2'b00, 2'b00, '0, 2'b01, 2'b00, 2'b00, 64'h77, '0, 1'b0);
        idleCycle();
        checkOutput("rst_unexp",  64'(bus.err_unexp), 64'h1);
        checkOutput("rst_no_vld", 64'(bus.out_vld), 64'h0);
        checkOutput("rst_busy0",  64'(bus.busy), 64'h0);

        randomPhase(500);
        idleCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/algo_2rw_rsp_track.md
ALGO_2RW_RSP_TRACK -- requirements
Module: algo_2rw_rsp_track

Interface
REQ-001 Parameter WIDTH, default 32, data width per port.
REQ-002 Parameter BITADDR, default 13, address width per port.
REQ-003 Parameter BITPADR, default 15, physical-address width per port.
REQ-004 Parameter READ_DELAY, default 3, cycles from accepted rw_read to expected rw_vld (range 1..16).
REQ-005 Parameter CNTW, default 16, width of each error counter.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 ready  input  1  memory ready; commands ignored while low.
REQ-009 rw_read, rw_write  input  2 each  per-port read/write strobes (bit p = port p).
REQ-010 rw_addr  input  2*BITADDR  per-port address, port p at [p*BITADDR +: BITADDR].
REQ-011 rw_vld, rw_serr, rw_derr  input  2 each  per-port read-valid, single-bit-error, double-bit-error from memory.
REQ-012 rw_dout  input  2*WIDTH; rw_padr  input  2*BITPADR  per-port read data and physical address.
REQ-013 clr  input  1  synchronous clear of sticky flags and counters.
REQ-014 out_vld  output  2; out_addr  output  2*BITADDR; out_dout  output  2*WIDTH; out_padr  output  2*BITPADR  registered tagged read responses.
REQ-015 out_serr, out_derr  output  2 each  registered error qualifiers of out_vld.
REQ-016 err_cmd, err_miss, err_unexp  output  2 each  sticky per-port flags.
REQ-017 serr_cnt, derr_cnt  output  2*CNTW each  per-port saturating counters.
REQ-018 busy  output  1  high while any read is outstanding on either port.

Function
REQ-019 A read on port p SHALL be accepted when ready=1, rw_read[p]=1, rw_write[p]=0.
REQ-020 rw_read[p]=rw_write[p]=1 with ready=1 SHALL set err_cmd[p] and SHALL NOT be tracked.
REQ-021 Commands while ready=0 SHALL be ignored entirely (no tracking, no flags).
REQ-022 Each port SHALL hold a READ_DELAY-deep shift pipe of {valid, addr}; accepted read enters stage 1 on the accepting edge.
REQ-023 At cycle READ_DELAY after acceptance, the pipe tail SHALL be compared with rw_vld[p].
REQ-024 Tail valid and rw_vld[p]=1: next edge SHALL drive out_vld[p]=1 with tail addr, rw_dout, rw_padr, rw_serr, rw_derr of port p.
REQ-025 Tail valid and rw_vld[p]=0: err_miss[p] SHALL set; no out_vld.
REQ-026 rw_vld[p]=1 with tail invalid: err_unexp[p] SHALL set; no out_vld.
REQ-027 out_vld SHALL be a single-cycle pulse; out_* data SHALL hold last value when out_vld=0.
REQ-028 On matched response, serr_cnt[p] SHALL increment if rw_serr[p]=1, derr_cnt[p] if rw_derr[p]=1 (both may increment same cycle).
REQ-029 Counters SHALL saturate at 2^CNTW-1, never wrap.
REQ-030 clr=1 SHALL zero all sticky flags and counters on that edge; clr wins over any same-cycle set/increment; clr SHALL NOT flush pipes or out_*.
REQ-031 busy SHALL equal OR of all pipe valid bits of both ports.
REQ-032 Back-to-back reads every cycle SHALL be tracked without loss; ports SHALL be fully independent.
REQ-033 Response latency, acceptance to out_vld, SHALL be exactly READ_DELAY+1 cycles.

Reset
REQ-034 rst=0 SHALL asynchronously clear pipes, out_vld, out_addr, out_dout, out_padr, out_serr, out_derr, all sticky flags, counters, busy to 0.
REQ-035 Reset mid-operation SHALL discard in-flight reads; rw_vld arriving after reset release for a discarded read SHALL set err_unexp.
REQ-036 Outputs SHALL be glitch-free from the first edge after rst deasserts.

Verification (READ_DELAY=3, CNTW=4)
REQ-037 Port0 read addr 0x12 cycle 0, rw_vld[0]=1 cycle 3 dout 0xA5A5 -> out_vld[0]=1 cycle 4, out_addr 0x12, out_dout 0xA5A5, no flags.
REQ-038 Port1 reads cycles 0,1,2 addr 1,2,3, rw_vld[1] only cycles 3 and 5 -> out_vld[1] cycles 4 (addr 1) and 6 (addr 3), err_miss[1]=1 from cycle 5.
REQ-039 rw_vld[0]=1 with no outstanding read -> err_unexp[0]=1 next cycle; clr pulse -> 0.
REQ-040 18 matched responses with rw_derr[0]=1 -> derr_cnt[0] stops at 15.
REQ-041 rw_read[1]=rw_write[1]=1, ready=1 -> err_cmd[1]=1, busy stays 0; same with ready=0 -> no flag.
REQ-042 Read accepted, rst=0 pulse at cycle 1, rw_vld cycle 3 -> no out_vld, err_unexp=1, busy=0 after reset.
